// File: rtl/umac_ctrl_pkg.sv
// Shared types and helpers for the bipolar stochastic MAC lane sequencer.
// Contents:
//   state_t        sequencer states
//   LEN_LOG2_DEF   default log2 of the bitstream window
//   N/CNT_W/VAL_W  window length and result widths for the default window
//   bipolar()      ones count -> signed bipolar value (2*count - 2^len_log2)
package umac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int LEN_LOG2_DEF = 8;
  localparam int N            = 1 << LEN_LOG2_DEF;
  localparam int CNT_W        = LEN_LOG2_DEF + 1;
  localparam int VAL_W        = LEN_LOG2_DEF + 2;

  // The count is sign-extended and doubled before N is subtracted.
  // Callers truncate the result to their own value width.
  function automatic logic signed [31:0] bipolar(input logic [31:0] count,
                                                 input int          len_log2);
    return $signed(count << 1) - $signed(32'd1 << len_log2);
  endfunction

endpackage

// File: rtl/ubit_acc.sv
// Window counter plus ones counter for one output bitstream.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         restart the window and zero the ones count
//   en          window cycle active; sbit is counted when en=1
//   sbit        bitstream sample
//   count       ones counted so far in the window (LEN_LOG2+1 bits)
//   last        high in the final cycle of the window (en=1 and window expired)
module ubit_acc #(
  parameter int LEN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic                sbit,
  output logic [LEN_LOG2:0]   count,
  output logic                last
);

  // Down-counter loaded with N-1; the terminal count marks the window end.
  logic [LEN_LOG2-1:0] win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win   <= '1;
      count <= '0;
    end else if (clr) begin
      win   <= '1;
      count <= '0;
    end else if (en) begin
      win   <= win - 1'b1;
      count <= count + {{LEN_LOG2{1'b0}}, sbit};
    end
  end

  assign last = en && (win == '0);

endmodule

// File: rtl/umac_bi_seq_ctrl.sv
// Sequencer for one 16-input bipolar scaled stochastic MAC lane.
// Accepts a job of NIN 8-bit weights, strobes the MAC weight load, masks
// MAC_LAT warm-up cycles, counts ones on mac_oC over 2^LEN_LOG2 cycles and
// returns the count and its bipolar value through a valid/ready handshake.
// Ports:
//   cfg_valid/cfg_ready/cfg_w   job request handshake and packed weights
//   abort                       synchronous cancel of the current job
//   mac_loadB/mac_iB/mac_run    MAC lane control and latched weights
//   mac_oC                      MAC output bitstream
//   res_valid/res_ready         result handshake
//   res_count/res_value         ones count and signed value 2*count - N
//   busy                        job in progress
//
// state | meaning
// IDLE  | waiting for a job, cfg_ready=1
// LOAD  | one-cycle weight-load strobe to the MAC
// WARM  | MAC_LAT cycles of pipeline fill, mac_oC ignored
// RUN   | N-cycle counting window
// DONE  | result presented until res_ready (or abort)
module umac_bi_seq_ctrl
  import umac_ctrl_pkg::*;
#(
  parameter int LEN_LOG2 = LEN_LOG2_DEF,
  parameter int MAC_LAT  = 2,
  parameter int NIN      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [NIN*8-1:0]      cfg_w,
  input  logic                  abort,
  output logic                  mac_loadB,
  output logic [NIN*8-1:0]      mac_iB,
  output logic                  mac_run,
  input  logic                  mac_oC,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [LEN_LOG2:0]     res_count,
  output logic [LEN_LOG2+1:0]   res_value,
  output logic                  busy
);

  localparam int WIN_CW = LEN_LOG2 + 1;
  localparam int WIN_VW = LEN_LOG2 + 2;
  localparam logic [3:0] WARM_LD = (MAC_LAT > 0) ? 4'(MAC_LAT - 1) : 4'd0;

  state_t state, state_nxt;

  logic              accept;
  logic [3:0]        wcnt;
  logic [WIN_CW-1:0] acc_count;
  logic [WIN_CW-1:0] fin_count;
  logic              acc_last;

  assign accept = (state == IDLE) && cfg_valid;

  ubit_acc #(.LEN_LOG2(LEN_LOG2)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == RUN),
    .sbit  (mac_oC),
    .count (acc_count),
    .last  (acc_last)
  );

  // The last window bit is still in flight in acc_last's cycle.
  assign fin_count = acc_count + {{(WIN_CW-1){1'b0}}, mac_oC};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_valid) state_nxt = LOAD;
      LOAD: if (abort)                state_nxt = IDLE;
            else if (MAC_LAT == 0)    state_nxt = RUN;
            else                      state_nxt = WARM;
      WARM: if (abort)                state_nxt = IDLE;
            else if (wcnt == 4'd0)    state_nxt = RUN;
      RUN:  if (abort)                state_nxt = IDLE;
            else if (acc_last)        state_nxt = DONE;
      DONE: if (abort || res_ready)   state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    mac_loadB = 1'b0;
    mac_run   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin cfg_ready = 1'b1; busy = 1'b0; end
      LOAD: mac_loadB = 1'b1;
      WARM: mac_run   = 1'b1;
      RUN:  mac_run   = 1'b1;
      DONE: res_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_iB    <= '0;
      wcnt      <= '0;
      res_count <= '0;
      res_value <= '0;
    end else begin
      if (accept) mac_iB <= cfg_w;
      if (state == LOAD)                   wcnt <= WARM_LD;
      else if (state == WARM && wcnt != 0) wcnt <= wcnt - 4'd1;
      if (state == RUN && acc_last && !abort) begin
        res_count <= fin_count;
        res_value <= WIN_VW'(bipolar(32'(fin_count), LEN_LOG2));
      end
    end
  end

endmodule

// File: doc/umac_bi_seq_ctrl.md
Name: umac_bi_seq_ctrl

Overview:
Sequencer for one 16-input bipolar scaled stochastic MAC lane (16 bipolar multipliers feeding a scaled 16:1 adder). It accepts a job of 16 8-bit weights through a valid/ready handshake and pulses the MAC's weight-load strobe. It then masks the MAC pipeline warm-up and counts ones on the MAC output bitstream over a fixed window of 2^LEN_LOG2 cycles. It returns the ones count and its bipolar signed value through a second valid/ready handshake. It sits between the layer scheduler and the MAC lane.

Parameters:
LEN_LOG2, 8, log2 of the bitstream window length; window N = 2^LEN_LOG2 cycles.
MAC_LAT, 2, cycles from mac_run assertion to the first valid mac_oC bit; range 0..15.
NIN, 16, MAC fan-in (number of weights); fixed at 16 for this revision.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  job request
cfg_ready  out  1  controller can accept a job (high only in IDLE)
cfg_w  in  NIN*8  packed weights; weight i at bits [8i+7:8i]
abort  in  1  synchronous cancel of the current job
mac_loadB  out  1  one-cycle weight-load strobe to the MAC
mac_iB  out  NIN*8  latched weights driven to the MAC
mac_run  out  1  enables the input bitstream generators for the MAC
mac_oC  in  1  MAC output bitstream
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_count  out  LEN_LOG2+1  ones counted in window
res_value  out  LEN_LOG2+2  signed bipolar value = 2*res_count - N
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mac_loadB=0, mac_run=0, res_valid=0, res_count=0, res_value=0, mac_iB=0, busy=0. cfg_ready=1 once rst_n releases.
- States: IDLE -> LOAD -> WARM -> RUN -> DONE -> IDLE.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready at edge T, latch cfg_w into mac_iB, clear counters, go to LOAD.
- LOAD (cycle T+1): mac_loadB=1 for exactly one cycle, mac_run=0. Next state is WARM, or RUN directly when MAC_LAT=0.
- WARM (MAC_LAT cycles): mac_run=1; mac_oC ignored.
- RUN (N cycles): mac_run=1; count increments when mac_oC=1. The window counter wraps from N-1 to exit; the ones counter is LEN_LOG2+1 bits, so a count of N never overflows.
- DONE: mac_run=0. res_valid=1 from cycle T+2+MAC_LAT+N. With defaults, res_valid rises at T+260.
- DONE outputs: res_count and res_value are held stable while res_valid=1 && res_ready=0. On res_valid&res_ready, go to IDLE; res_valid drops the next cycle.
- cfg_ready is 0 during LOAD..DONE. A cfg_valid held high in DONE is accepted only after the return to IDLE, i.e. no same-cycle hand-off.
- res_value arithmetic: sign-extend {res_count,1'b0} then subtract N. Range -N..+N.
- abort: in LOAD/WARM/RUN/DONE, the next state is IDLE. mac_run=0 and mac_loadB=0 next cycle. res_valid is never raised for the aborted job, or is dropped if already in DONE. abort in IDLE has no effect. abort has priority over the res_ready handshake.
- mac_iB holds its value until the next accepted job; it is not cleared by abort.
- Reset mid-operation returns all outputs to their reset values immediately.

Decomposition:
- Package umac_ctrl_pkg:
  - state enum (IDLE, LOAD, WARM, RUN, DONE);
  - localparams N = 1<<LEN_LOG2, CNT_W = LEN_LOG2+1, VAL_W = LEN_LOG2+2;
  - function for the bipolar conversion.
- Sub-module ubit_acc: window counter plus ones counter. Inputs are clr, en, bit; outputs are count and last (window end).

Test Plan:
- Defaults, mac_oC tied 1, res_ready=1 -> res_count=256, res_value=+256; res_valid rises exactly 260 cycles after the accept edge; mac_loadB high exactly one cycle at T+1.
- mac_oC tied 0 -> res_count=0, res_value=-256. mac_oC toggling 1,0,1,0 from the first RUN cycle -> res_count=128, res_value=0.
- cfg_w = 0x01..0x10 ramp -> mac_iB equals the ramp from T+1. mac_oC=1 during WARM only and 0 in RUN -> res_count=0, confirming warm-up masking.
- Backpressure: res_ready=0 for 20 cycles after res_valid -> res_count/res_value stable, cfg_ready=0 throughout. A cfg_valid held high is accepted only on the cycle after the res handshake.
- abort at RUN cycle 100 -> IDLE next cycle, mac_run=0, no res_valid. A following job with mac_oC=1 -> res_count=256 (no stale count).
- rst_n pulsed low mid-RUN -> all outputs at reset values immediately, cfg_ready=1 after release. Repeat the job with MAC_LAT=0 -> res_valid at T+258.
